ntt_coef_ram: RTL and testbench

//  Memory responder for ntt_processor. Serves r_data for r_data_addr and absorbs w_data/w_data_addr/w_data_en.

---
 rtl/kyber_pkg.sv | 14 +
 rtl/ntt_ram_array.sv | 18 +
 rtl/ntt_coef_ram.sv | 81 ++++++++
 tb/tb_ntt_coef_ram.sv | 134 +++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// kyber_pkg: shared widths, the Kyber modulus and the host-port state encoding.
package kyber_pkg;
  localparam int COEF_W = 12;
  localparam int COEFS = 8;
  localparam int DATA_W = COEF_W * COEFS;
  localparam int ADDR_W = 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [COEF_W-1:0] KYBER_Q = 12'd3329;
  typedef enum logic [1:0] {H_IDLE, H_ACCESS, H_ACK} host_st_t;
  function automatic logic coef_bad(input logic [DATA_W-1:0] w);
    coef_bad = 1'b0;
    for (int i = 0; i < COEFS; i++) coef_bad |= w[i*COEF_W +: COEF_W] >= KYBER_Q;
  endfunction
endpackage

// File: rtl/ntt_ram_array.sv
// ntt_ram_array: simple dual-port storage, one write port and one registered read port.
module ntt_ram_array #(
  parameter int DW = 96,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ntt_coef_ram.sv
// ntt_coef_ram: coefficient store for the NTT core with host load/dump port, clear engine and range check.
module ntt_coef_ram
  import kyber_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] core_raddr,
  output logic [DATA_W-1:0] core_rdata,
  input  logic [ADDR_W-1:0] core_waddr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_wen,
  input  logic              core_active,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              err_coef,
  input  logic              err_clr
);
  host_st_t st;
  logic [ADDR_W-1:0] h_addr, clr_cnt, wr_addr, rd_addr;
  logic [DATA_W-1:0] h_data, wr_data, ram_rdata, byp_data, rd_data;
  logic h_we, h_wr, h_rd, wr_en, byp, rd_vld;
  assign h_wr = st == H_ACCESS && h_we;
  assign h_rd = st == H_ACCESS && !h_we;
  assign wr_en = clear_busy || h_wr || core_wen;
  assign wr_addr = clear_busy ? clr_cnt : h_wr ? h_addr : core_waddr;
  assign wr_data = clear_busy ? '0 : h_wr ? h_data : core_wdata;
  // A host read borrows the read port for one cycle; the core is idle whenever a host access is accepted.
  assign rd_addr = h_rd ? h_addr : core_raddr;
  assign rd_data = !rd_vld ? '0 : byp ? byp_data : ram_rdata;
  assign core_rdata = rd_data;
  assign host_rdata = host_ack ? rd_data : '0;
  ntt_ram_array #(.DW(DATA_W), .AW(ADDR_W)) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= H_IDLE;
      h_addr <= '0;
      h_data <= '0;
      h_we <= 1'b0;
      host_ack <= 1'b0;
      clear_busy <= 1'b0;
      clr_cnt <= '0;
      err_coef <= 1'b0;
      byp <= 1'b0;
      byp_data <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= 1'b1;
      byp <= wr_en && wr_addr == rd_addr;
      byp_data <= wr_data;
      err_coef <= err_clr ? 1'b0 : err_coef | (wr_en && coef_bad(wr_data));
      host_ack <= st == H_ACCESS;
      if (st == H_IDLE && host_req && !core_active && !clear_busy) begin
        st <= H_ACCESS;
        h_addr <= host_addr;
        h_data <= host_wdata;
        h_we <= host_we;
      end else if (st == H_ACCESS) st <= H_ACK;
      else if (st == H_ACK) st <= H_IDLE;
      if (clear_busy) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == '1) clear_busy <= 1'b0;
      end else if (clear_start) begin
        clear_busy <= 1'b1;
        clr_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ntt_coef_ram.sv
// tb_ntt_coef_ram: directed vectors against hand-computed results for ntt_coef_ram.
module tb_ntt_coef_ram;
  logic clk = 0, rst_n = 0;
  logic [7:0] core_raddr = 0, core_waddr = 0, host_addr = 0;
  logic [95:0] core_rdata, core_wdata = 0, host_wdata = 0, host_rdata;
  logic core_wen = 0, core_active = 0, host_req = 0, host_we = 0, host_ack;
  logic clear_start = 0, clear_busy, err_coef, err_clr = 0;
  int n_chk = 0, n_pass = 0;
  localparam logic [95:0] W0 = {12'd193, 12'd192, 12'd65, 12'd64, 12'd129, 12'd128, 12'd1, 12'd0};
  localparam logic [95:0] W7 = {8{12'd7}};
  ntt_coef_ram dut (
    .clk(clk), .rst_n(rst_n), .core_raddr(core_raddr), .core_rdata(core_rdata),
    .core_waddr(core_waddr), .core_wdata(core_wdata), .core_wen(core_wen),
    .core_active(core_active), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .clear_start(clear_start), .clear_busy(clear_busy),
    .err_coef(err_coef), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask
  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!host_ack && lat < 20);
    if (!host_ack) lat = -1;
  endtask
  int lat, n;
  logic any_ack;
  logic [11:0] v;
  initial begin
    step();
    step();
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_host_ack", 96'(host_ack), 0);
    chk("rst_clear_busy", 96'(clear_busy), 0);
    chk("rst_err_coef", 96'(err_coef), 0);
    rst_n = 1;
    step();
    host_req = 1; host_we = 1; host_addr = 0; host_wdata = W0;
    wait_ack(lat);
    host_req = 0; host_we = 0;
    chk("hw_latency", 96'(lat), 2);
    core_raddr = 0;
    step();
    chk("hw_readback", core_rdata, W0);
    chk("hw_no_err", 96'(err_coef), 0);
    core_wen = 1; core_waddr = 5; core_raddr = 5; core_wdata = W7;
    step();
    core_wen = 0;
    chk("bypass", core_rdata, W7);
    step();
    chk("stored_5", core_rdata, W7);
    core_wen = 1; core_waddr = 10; core_wdata = 96'd3328 << 36;
    step();
    core_wen = 0;
    chk("range_3328", 96'(err_coef), 0);
    core_wen = 1; core_wdata = 96'd3329 << 36;
    step();
    core_wen = 0;
    chk("range_3329", 96'(err_coef), 1);
    step(); step(); step();
    chk("err_sticky", 96'(err_coef), 1);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("err_cleared", 96'(err_coef), 0);
    err_clr = 1; core_wen = 1; core_wdata = 96'hFFF;
    step();
    err_clr = 0; core_wen = 0;
    chk("err_clr_priority", 96'(err_coef), 0);
    core_active = 1; host_req = 1; host_we = 0; host_addr = 5; any_ack = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      any_ack |= host_ack;
    end
    chk("arb_blocked", 96'(any_ack), 0);
    core_active = 0;
    wait_ack(lat);
    chk("arb_latency", 96'(lat), 2);
    chk("arb_rdata", host_rdata, W7);
    host_req = 0;
    step();
    for (int a = 0; a < 256; a++) begin
      v = 12'(a + 1);
      core_wen = 1; core_waddr = 8'(a); core_wdata = {8{v}};
      step();
    end
    core_wen = 0; core_raddr = 128;
    step();
    chk("fill_128", core_rdata, {8{12'd129}});
    clear_start = 1;
    step();
    clear_start = 0;
    n = 0;
    while (clear_busy && n < 300) begin
      n++;
      clear_start = n == 50;
      core_wen = n == 100; core_waddr = 3; core_wdata = W7;
      step();
    end
    clear_start = 0; core_wen = 0;
    chk("clear_cycles", 96'(n), 256);
    foreach (W0[i]) if (i < 4) begin
      core_raddr = i == 0 ? 8'd0 : i == 1 ? 8'd128 : i == 2 ? 8'd255 : 8'd3;
      step();
      chk($sformatf("cleared_%0d", core_raddr), core_rdata, 0);
    end
    clear_start = 1;
    step();
    clear_start = 0;
    step(); step();
    rst_n = 0;
    #1;
    chk("async_rst_busy", 96'(clear_busy), 0);
    chk("async_rst_rdata", core_rdata, 0);
    chk("async_rst_ack", 96'(host_ack), 0);
    rst_n = 1;
    step(); step(); step();
    chk("post_rst_busy", 96'(clear_busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
